// File: rtl/wb_app_pkg.sv
// Shared types and helpers for the Wishbone-to-app-interface responder.
// Contents:
//   wb_app_state_t     responder FSM states
//   APP_CMD_WRITE/READ native app interface command encodings
//   word_to_app_addr   byte address -> app column address
package wb_app_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdCmd,
    StRdWait,
    StResp
  } wb_app_state_t;

  localparam logic [2:0] APP_CMD_WRITE = 3'b000;
  localparam logic [2:0] APP_CMD_READ  = 3'b001;

  // Drop the byte offset within a data word, then scale the word index to
  // the column granularity the app interface expects.
  function automatic logic [31:0] word_to_app_addr(input logic [31:0] byte_addr,
                                                   input int unsigned off_bits,
                                                   input int unsigned shift);
    return (byte_addr >> off_bits) << shift;
  endfunction

endpackage

// File: rtl/wb_app_responder_if.sv
// Bus bundle for wb_app_responder: Wishbone classic target side, MIG-style
// native app interface (cmd/wdf/rd channels), calibration status and busy.
// Signal suffixes are from the responder's point of view.
// Modports:
//   slave  - the responder
//   master - initiator plus PHY/UI model (drives every responder input)
interface wb_app_responder_if #(
  parameter int unsigned WORD_SIZE  = 128,
  parameter int unsigned APP_ADDR_W = 28
);
  logic                    cyc_i;
  logic                    stb_i;
  logic                    we_i;
  logic [31:0]             addr_i;
  logic [WORD_SIZE-1:0]    data_i;
  logic [WORD_SIZE-1:0]    data_o;
  logic                    ack_o;
  logic                    err_o;
  logic                    busy_o;
  logic                    calib_done_i;
  logic [APP_ADDR_W-1:0]   app_addr_o;
  logic [2:0]              app_cmd_o;
  logic                    app_en_o;
  logic                    app_rdy_i;
  logic [WORD_SIZE-1:0]    app_wdf_data_o;
  logic                    app_wdf_wren_o;
  logic                    app_wdf_end_o;
  logic [WORD_SIZE/8-1:0]  app_wdf_mask_o;
  logic                    app_wdf_rdy_i;
  logic [WORD_SIZE-1:0]    app_rd_data_i;
  logic                    app_rd_data_valid_i;

  modport slave (
    input  cyc_i, stb_i, we_i, addr_i, data_i, calib_done_i,
           app_rdy_i, app_wdf_rdy_i, app_rd_data_i, app_rd_data_valid_i,
    output data_o, ack_o, err_o, busy_o, app_addr_o, app_cmd_o, app_en_o,
           app_wdf_data_o, app_wdf_wren_o, app_wdf_end_o, app_wdf_mask_o
  );

  modport master (
    output cyc_i, stb_i, we_i, addr_i, data_i, calib_done_i,
           app_rdy_i, app_wdf_rdy_i, app_rd_data_i, app_rd_data_valid_i,
    input  data_o, ack_o, err_o, busy_o, app_addr_o, app_cmd_o, app_en_o,
           app_wdf_data_o, app_wdf_wren_o, app_wdf_end_o, app_wdf_mask_o
  );
endinterface

// File: rtl/wb_app_responder.sv
// Wishbone classic responder driving a MIG-style native app interface.
// One outstanding transaction; requests are refused with err_o while the PHY
// is uncalibrated, and a bus timeout turns a stuck transaction into err_o.
// Ports:
//   user_clk_i  user clock, all logic on its rising edge
//   rst_i       synchronous active-high reset
//   bus         wb_app_responder_if.slave (Wishbone + app interface + busy)
module wb_app_responder
  import wb_app_pkg::*;
#(
  parameter int unsigned WORD_SIZE      = 128,
  parameter int unsigned APP_ADDR_W     = 28,
  parameter int unsigned ADDR_SHIFT     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input logic                 user_clk_i,
  input logic                 rst_i,
  wb_app_responder_if.slave   bus
);

  localparam int unsigned    OffBits = $clog2(WORD_SIZE / 8);
  localparam int unsigned    CntW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  wb_app_state_t         state_q, state_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  app_en_q, app_en_d;
  logic                  wdf_wren_q, wdf_wren_d;
  logic                  cmd_done_q, cmd_done_d;
  logic                  wdf_done_q, wdf_done_d;
  logic                  abort_q, abort_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [WORD_SIZE-1:0]  data_q, data_d;
  logic [APP_ADDR_W-1:0] app_addr_q, app_addr_d;
  logic [2:0]            app_cmd_q, app_cmd_d;
  logic [WORD_SIZE-1:0]  wdf_data_q, wdf_data_d;

  logic req, busy, abort_set, timed_out, cmd_hs, wdf_hs;

  assign req       = bus.cyc_i & bus.stb_i & ~ack_q & ~err_q;
  assign busy      = (state_q != StIdle);
  // Abort is sticky until the response slot so the DRAM side can finish.
  assign abort_set = abort_q | (busy & ~bus.cyc_i);
  assign timed_out = (cnt_q == CntLast);
  assign cmd_hs    = app_en_q & bus.app_rdy_i;
  assign wdf_hs    = wdf_wren_q & bus.app_wdf_rdy_i;

  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    app_en_d   = app_en_q;
    wdf_wren_d = wdf_wren_q;
    cmd_done_d = cmd_done_q;
    wdf_done_d = wdf_done_q;
    abort_d    = abort_set;
    cnt_d      = cnt_q;
    data_d     = data_q;
    app_addr_d = app_addr_q;
    app_cmd_d  = app_cmd_q;
    wdf_data_d = wdf_data_q;

    unique case (state_q)
      StIdle: begin
        cnt_d      = '0;
        abort_d    = 1'b0;
        cmd_done_d = 1'b0;
        wdf_done_d = 1'b0;
        if (req) begin
          if (!bus.calib_done_i) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            app_addr_d = APP_ADDR_W'(word_to_app_addr(bus.addr_i, OffBits, ADDR_SHIFT));
            app_en_d   = 1'b1;
            if (bus.we_i) begin
              app_cmd_d  = APP_CMD_WRITE;
              wdf_data_d = bus.data_i;
              wdf_wren_d = 1'b1;
              state_d    = StWr;
            end else begin
              app_cmd_d = APP_CMD_READ;
              state_d   = StRdCmd;
            end
          end
        end
      end

      StWr: begin
        cnt_d      = cnt_q + 1'b1;
        cmd_done_d = cmd_done_q | cmd_hs;
        wdf_done_d = wdf_done_q | wdf_hs;
        app_en_d   = app_en_q & ~bus.app_rdy_i;
        wdf_wren_d = wdf_wren_q & ~bus.app_wdf_rdy_i;
        if (cmd_done_d && wdf_done_d) begin
          ack_d   = ~abort_set;
          state_d = StResp;
        end else if (timed_out) begin
          app_en_d   = 1'b0;
          wdf_wren_d = 1'b0;
          err_d      = ~abort_set;
          state_d    = StResp;
        end
      end

      StRdCmd: begin
        cnt_d = cnt_q + 1'b1;
        if (cmd_hs) begin
          app_en_d = 1'b0;
          state_d  = StRdWait;
        end else if (timed_out) begin
          app_en_d = 1'b0;
          err_d    = ~abort_set;
          state_d  = StResp;
        end
      end

      StRdWait: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.app_rd_data_valid_i) begin
          data_d  = bus.app_rd_data_i;
          ack_d   = ~abort_set;
          state_d = StResp;
        end else if (timed_out) begin
          err_d   = ~abort_set;
          state_d = StResp;
        end
      end

      StResp: begin
        abort_d = 1'b0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge user_clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      app_en_q   <= 1'b0;
      wdf_wren_q <= 1'b0;
      cmd_done_q <= 1'b0;
      wdf_done_q <= 1'b0;
      abort_q    <= 1'b0;
      cnt_q      <= '0;
      data_q     <= '0;
      app_addr_q <= '0;
      app_cmd_q  <= APP_CMD_READ;
      wdf_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      app_en_q   <= app_en_d;
      wdf_wren_q <= wdf_wren_d;
      cmd_done_q <= cmd_done_d;
      wdf_done_q <= wdf_done_d;
      abort_q    <= abort_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      app_addr_q <= app_addr_d;
      app_cmd_q  <= app_cmd_d;
      wdf_data_q <= wdf_data_d;
    end
  end

  assign bus.data_o         = data_q;
  assign bus.ack_o          = ack_q;
  assign bus.err_o          = err_q;
  assign bus.busy_o         = busy;
  assign bus.app_addr_o     = app_addr_q;
  assign bus.app_cmd_o      = app_cmd_q;
  assign bus.app_en_o       = app_en_q;
  assign bus.app_wdf_data_o = wdf_data_q;
  assign bus.app_wdf_wren_o = wdf_wren_q;
  assign bus.app_wdf_end_o  = wdf_wren_q;
  assign bus.app_wdf_mask_o = '0;

endmodule

// File: tb/tb_wb_app_responder.sv
// Self-checking bench for wb_app_responder: directed scenarios plus random
// transactions, each compared against timing/address rules computed here.
module tb_wb_app_responder;

  localparam int unsigned W  = 128;
  localparam int unsigned AW = 28;
  localparam int unsigned SH = 3;
  localparam int unsigned TO = 16;

  typedef struct {
    int           ack_at;
    int           err_at;
    int           ack_cnt;
    int           err_cnt;
    int           en_cyc;
    int           wren_cyc;
    logic         busy0;
    logic [AW-1:0] addr0;
    logic [2:0]   cmd0;
    logic [W-1:0] wdata0;
    logic [W-1:0] data_ack;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  wb_app_responder_if #(.WORD_SIZE(W), .APP_ADDR_W(AW)) bus ();

  wb_app_responder #(
    .WORD_SIZE      (W),
    .APP_ADDR_W     (AW),
    .ADDR_SHIFT     (SH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .user_clk_i (clk),
    .rst_i      (rst),
    .bus        (bus)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Word index times column scale, wrapped to the app address width.
  function automatic logic [AW-1:0] model_addr(input logic [31:0] a);
    longint unsigned word_idx;
    word_idx = longint'(a) / (W / 8);
    return AW'(word_idx * (longint'(1) << SH));
  endfunction

  // Drives one request from cycle 0. The app side accepts the command from
  // cycle 1+cd, the write data from cycle 1+wd, and pulses read data valid
  // rdd cycles after command acceptance (rdd<0: never). Index k is the edge
  // after which outputs are observed.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [W-1:0] wdata,
                         input int cd, input int wd, input int rdd, input logic [W-1:0] rdata,
                         input int drop_at, input int rst_at, input int ncyc, output res_t r);
    r = '{ack_at: -1, err_at: -1, ack_cnt: 0, err_cnt: 0, en_cyc: 0, wren_cyc: 0,
          busy0: 1'b0, addr0: '0, cmd0: '0, wdata0: '0, data_ack: '0};
    bus.cyc_i  = 1'b1;
    bus.stb_i  = 1'b1;
    bus.we_i   = we;
    bus.addr_i = addr;
    bus.data_i = wdata;
    for (int k = 0; k < ncyc; k++) begin
      bus.app_rdy_i           = (k >= 1 + cd);
      bus.app_wdf_rdy_i       = (k >= 1 + wd);
      bus.app_rd_data_valid_i = (rdd >= 0) && (k == 1 + cd + rdd);
      bus.app_rd_data_i       = rdata;
      rst                     = (k == rst_at);
      if (k == drop_at || k == rst_at) begin
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
      end
      @(posedge clk);
      #1;
      if (k == 0) begin
        r.busy0  = bus.busy_o;
        r.addr0  = bus.app_addr_o;
        r.cmd0   = bus.app_cmd_o;
        r.wdata0 = bus.app_wdf_data_o;
      end
      if (bus.ack_o) begin
        if (r.ack_cnt == 0) begin
          r.ack_at   = k;
          r.data_ack = bus.data_o;
        end
        r.ack_cnt++;
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
      end
      if (bus.err_o) begin
        if (r.err_cnt == 0) r.err_at = k;
        r.err_cnt++;
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
      end
      if (bus.app_en_o) r.en_cyc++;
      if (bus.app_wdf_wren_o) r.wren_cyc++;
    end
    bus.cyc_i               = 1'b0;
    bus.stb_i               = 1'b0;
    bus.app_rdy_i           = 1'b0;
    bus.app_wdf_rdy_i       = 1'b0;
    bus.app_rd_data_valid_i = 1'b0;
    rst                     = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    res_t            r;
    logic [W-1:0]    last_rd;
    logic [W-1:0]    pat_a5;
    logic [W-1:0]    pat_rd;
    logic [W-1:0]    wd_r;
    logic [W-1:0]    rd_r;
    logic [31:0]     a_r;
    logic            we_r;
    int              cd_r, wd_dly, rdd_r, exp_ack;

    pat_a5  = {16{8'hA5}};
    pat_rd  = {2{64'h0123_4567_89AB_CDEF}};
    last_rd = '0;

    rst                     = 1'b1;
    bus.cyc_i               = 1'b0;
    bus.stb_i               = 1'b0;
    bus.we_i                = 1'b0;
    bus.addr_i              = '0;
    bus.data_i              = '0;
    bus.calib_done_i        = 1'b1;
    bus.app_rdy_i           = 1'b0;
    bus.app_wdf_rdy_i       = 1'b0;
    bus.app_rd_data_i       = '0;
    bus.app_rd_data_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",  W'(bus.ack_o), W'(0));
    check("rst_err",  W'(bus.err_o), W'(0));
    check("rst_en",   W'(bus.app_en_o), W'(0));
    check("rst_wren", W'(bus.app_wdf_wren_o), W'(0));
    check("rst_busy", W'(bus.busy_o), W'(0));
    check("rst_cmd",  W'(bus.app_cmd_o), W'(3'b001));
    check("rst_addr", W'(bus.app_addr_o), W'(0));
    check("rst_data", bus.data_o, W'(0));
    check("rst_mask", W'(bus.app_wdf_mask_o), W'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero-wait write.
    run_txn(1'b1, 32'h0, pat_a5, 0, 0, -1, '0, -1, -1, 6, r);
    check("w0_addr",  W'(r.addr0), W'(model_addr(32'h0)));
    check("w0_cmd",   W'(r.cmd0), W'(3'b000));
    check("w0_wdata", r.wdata0, pat_a5);
    check("w0_busy",  W'(r.busy0), W'(1));
    check("w0_ackat", W'(r.ack_at), W'(1));
    check("w0_ackn",  W'(r.ack_cnt), W'(1));
    check("w0_errn",  W'(r.err_cnt), W'(0));
    check("w0_data",  r.data_ack, last_rd);

    // Read with 3 cycles of command backpressure, data 5 cycles later.
    run_txn(1'b0, 32'h10, '0, 3, 0, 5, pat_rd, -1, -1, 14, r);
    last_rd = pat_rd;
    check("r0_addr",  W'(r.addr0), W'(28'h8));
    check("r0_cmd",   W'(r.cmd0), W'(3'b001));
    check("r0_enc",   W'(r.en_cyc), W'(4));
    check("r0_ackat", W'(r.ack_at), W'(9));
    check("r0_ackn",  W'(r.ack_cnt), W'(1));
    check("r0_data",  r.data_ack, pat_rd);

    // Write data channel stalled for 4 cycles.
    run_txn(1'b1, 32'h40, ~pat_a5, 0, 4, -1, '0, -1, -1, 10, r);
    check("w1_enc",   W'(r.en_cyc), W'(1));
    check("w1_wrenc", W'(r.wren_cyc), W'(5));
    check("w1_ackat", W'(r.ack_at), W'(5));
    check("w1_ackn",  W'(r.ack_cnt), W'(1));
    check("w1_data",  r.data_ack, last_rd);

    // Uncalibrated PHY.
    bus.calib_done_i = 1'b0;
    run_txn(1'b1, 32'h80, pat_a5, 0, 0, -1, '0, -1, -1, 5, r);
    bus.calib_done_i = 1'b1;
    check("nc_enc",   W'(r.en_cyc), W'(0));
    check("nc_errat", W'(r.err_at), W'(0));
    check("nc_errn",  W'(r.err_cnt), W'(1));
    check("nc_ackn",  W'(r.ack_cnt), W'(0));

    // Read timeout, then a stray data valid long after.
    run_txn(1'b0, 32'h100, '0, 0, 0, 19, ~pat_rd, -1, -1, 26, r);
    check("to_errat", W'(r.err_at), W'(TO));
    check("to_errn",  W'(r.err_cnt), W'(1));
    check("to_ackn",  W'(r.ack_cnt), W'(0));
    check("to_data",  bus.data_o, last_rd);

    // Initiator abandons a read while it waits for data.
    run_txn(1'b0, 32'h200, '0, 0, 0, 4, ~pat_rd, 3, -1, 10, r);
    last_rd = ~pat_rd;
    check("ab_ackn",  W'(r.ack_cnt), W'(0));
    check("ab_errn",  W'(r.err_cnt), W'(0));

    // Reset in the middle of a write.
    run_txn(1'b1, 32'h300, pat_a5, 0, 5, -1, '0, -1, 2, 8, r);
    last_rd = '0;
    check("rw_ackn",  W'(r.ack_cnt), W'(0));
    check("rw_errn",  W'(r.err_cnt), W'(0));
    check("rw_wrenc", W'(r.wren_cyc), W'(2));
    check("rw_en",    W'(bus.app_en_o), W'(0));
    check("rw_wren",  W'(bus.app_wdf_wren_o), W'(0));
    check("rw_busy",  W'(bus.busy_o), W'(0));
    check("rw_addr",  W'(bus.app_addr_o), W'(0));
    check("rw_wdata", bus.app_wdf_data_o, W'(0));
    check("rw_data",  bus.data_o, W'(0));
    check("rw_cmd",   W'(bus.app_cmd_o), W'(3'b001));
    run_txn(1'b1, 32'h3F0, pat_rd, 0, 0, -1, '0, -1, -1, 6, r);
    check("rw_nackat", W'(r.ack_at), W'(1));
    check("rw_nackn",  W'(r.ack_cnt), W'(1));
    check("rw_naddr",  W'(r.addr0), W'(model_addr(32'h3F0)));

    // Random mix of reads and writes with random handshake delays.
    for (int i = 0; i < 12; i++) begin
      we_r   = 1'($urandom_range(0, 1));
      a_r    = $urandom;
      wd_r   = {$urandom, $urandom, $urandom, $urandom};
      rd_r   = {$urandom, $urandom, $urandom, $urandom};
      cd_r   = int'($urandom_range(0, 4));
      wd_dly = int'($urandom_range(0, 4));
      rdd_r  = int'($urandom_range(1, 5));
      run_txn(we_r, a_r, wd_r, cd_r, wd_dly, we_r ? -1 : rdd_r, rd_r, -1, -1, 14, r);
      if (we_r) begin
        exp_ack = 1 + ((cd_r > wd_dly) ? cd_r : wd_dly);
        check("rnd_wdata", r.wdata0, wd_r);
        check("rnd_wrenc", W'(r.wren_cyc), W'(1 + wd_dly));
      end else begin
        exp_ack = 1 + cd_r + rdd_r;
        last_rd = rd_r;
      end
      check("rnd_addr",  W'(r.addr0), W'(model_addr(a_r)));
      check("rnd_cmd",   W'(r.cmd0), we_r ? W'(3'b000) : W'(3'b001));
      check("rnd_enc",   W'(r.en_cyc), W'(1 + cd_r));
      check("rnd_ackat", W'(r.ack_at), W'(exp_ack));
      check("rnd_ackn",  W'(r.ack_cnt), W'(1));
      check("rnd_data",  r.data_ack, last_rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
